// File: rtl/ysyx_22041211_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional misaligned-redirect trapping is enabled by YSYX_22041211_IFU_ALIGN_CHK_EN.
package ysyx_22041211_ifu_pkg;

    typedef enum logic [1:0] {
        IFU_ST_IDLE = 2'd0,
        IFU_ST_REQ  = 2'd1,
        IFU_ST_WAIT = 2'd2,
        IFU_ST_HOLD = 2'd3
    } ifu_state_e;

    typedef enum logic [1:0] {
        PC_SEL_HOLD     = 2'd0,
        PC_SEL_REDIRECT = 2'd1,
        PC_SEL_TARGET   = 2'd2,
        PC_SEL_INC      = 2'd3
    } pc_sel_e;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] IFU_NOP_INST = 32'h0000_0013;

`ifdef YSYX_22041211_IFU_ALIGN_CHK_EN
    localparam bit IFU_ALIGN_CHK = 1'b1;
`else
    localparam bit IFU_ALIGN_CHK = 1'b0;
`endif

    // Without the alignment check the low bits are simply discarded.
    function automatic logic [31:0] capture_target(input logic [31:0] pc);
        return IFU_ALIGN_CHK ? pc : (pc & 32'hFFFF_FFFC);
    endfunction

    function automatic logic misaligned(input logic [31:0] pc);
        return IFU_ALIGN_CHK && (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/ysyx_22041211_pc_reg.sv
// Architectural PC register with its next-PC selection.
// Behaviour depends on YSYX_22041211_IFU_ALIGN_CHK_EN only through the values fed in.
module ysyx_22041211_pc_reg
    import ysyx_22041211_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  pc_sel_e     sel,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] target_pc,
    output logic [31:0] pc
);

    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc;
        case (sel)
            PC_SEL_REDIRECT: pc_d = redirect_pc;
            PC_SEL_TARGET:   pc_d = target_pc;
            PC_SEL_INC:      pc_d = pc + 32'd4;
            default:         pc_d = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_d;
        end
    end

endmodule

// File: rtl/ysyx_22041211_ifu.sv
// Instruction fetch unit: single outstanding imem read, one-word buffer toward the decoder.
// Define YSYX_22041211_IFU_ALIGN_CHK_EN to trap misaligned redirect targets without fetching.
module ysyx_22041211_ifu
    import ysyx_22041211_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter logic [31:0] NOP_INST = IFU_NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        imem_rsp_err_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        fault_o
);

    ifu_state_e  state_q, state_d;
    logic        kill_q, kill_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] inst_q, pc_out_q;
    logic        fault_q;
    logic        buf_load;
    logic [31:0] buf_inst_d, buf_pc_d;
    logic        buf_fault_d;
    pc_sel_e     pc_sel;
    logic [31:0] pc_q;
    logic [31:0] redirect_tgt;
    logic        redirect_mis, tgt_mis;

    assign redirect_tgt = capture_target(redirect_pc_i);
    assign redirect_mis = misaligned(redirect_pc_i);
    assign tgt_mis      = misaligned(tgt_q);

    ysyx_22041211_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel         (pc_sel),
        .redirect_pc (redirect_tgt),
        .target_pc   (tgt_q),
        .pc          (pc_q)
    );

    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        tgt_d       = tgt_q;
        pc_sel      = PC_SEL_HOLD;
        buf_load    = 1'b0;
        buf_inst_d  = NOP_INST;
        buf_pc_d    = redirect_tgt;
        buf_fault_d = 1'b1;
        case (state_q)
            IFU_ST_IDLE: begin
                state_d = IFU_ST_REQ;
                if (redirect_valid_i) begin
                    pc_sel = PC_SEL_REDIRECT;
                    if (redirect_mis) begin
                        buf_load = 1'b1;
                        state_d  = IFU_ST_HOLD;
                    end
                end
            end
            IFU_ST_REQ: begin
                // The presented address must not move, so a redirect only marks the fetch stale.
                if (redirect_valid_i) begin
                    kill_d = 1'b1;
                    tgt_d  = redirect_tgt;
                end
                if (imem_req_ready_i) begin
                    state_d = IFU_ST_WAIT;
                end
            end
            IFU_ST_WAIT: begin
                if (imem_rsp_valid_i) begin
                    if (redirect_valid_i) begin
                        kill_d  = 1'b0;
                        pc_sel  = PC_SEL_REDIRECT;
                        state_d = IFU_ST_REQ;
                        if (redirect_mis) begin
                            buf_load = 1'b1;
                            state_d  = IFU_ST_HOLD;
                        end
                    end else if (kill_q) begin
                        kill_d  = 1'b0;
                        pc_sel  = PC_SEL_TARGET;
                        state_d = IFU_ST_REQ;
                        if (tgt_mis) begin
                            buf_load = 1'b1;
                            buf_pc_d = tgt_q;
                            state_d  = IFU_ST_HOLD;
                        end
                    end else begin
                        buf_load    = 1'b1;
                        buf_inst_d  = imem_rsp_err_i ? NOP_INST : imem_rsp_data_i;
                        buf_pc_d    = pc_q;
                        buf_fault_d = imem_rsp_err_i;
                        state_d     = IFU_ST_HOLD;
                    end
                end else if (redirect_valid_i) begin
                    kill_d = 1'b1;
                    tgt_d  = redirect_tgt;
                end
            end
            IFU_ST_HOLD: begin
                // A redirect beats a same-cycle consume: the buffered word is wrong-path.
                if (redirect_valid_i) begin
                    pc_sel  = PC_SEL_REDIRECT;
                    state_d = IFU_ST_REQ;
                    if (redirect_mis) begin
                        buf_load = 1'b1;
                        state_d  = IFU_ST_HOLD;
                    end
                end else if (inst_ready_i) begin
                    pc_sel  = PC_SEL_INC;
                    state_d = IFU_ST_REQ;
                end
            end
            default: state_d = IFU_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IFU_ST_IDLE;
            kill_q   <= 1'b0;
            tgt_q    <= RESET_PC;
            inst_q   <= 32'd0;
            pc_out_q <= RESET_PC;
            fault_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            tgt_q   <= tgt_d;
            if (buf_load) begin
                inst_q   <= buf_inst_d;
                pc_out_q <= buf_pc_d;
                fault_q  <= buf_fault_d;
            end
        end
    end

    assign imem_req_valid_o = (state_q == IFU_ST_REQ);
    assign imem_req_addr_o  = pc_q;
    assign inst_valid_o     = (state_q == IFU_ST_HOLD);
    assign inst_o           = inst_q;
    assign pc_o             = pc_out_q;
    assign fault_o          = fault_q;

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Bench for the fetch unit: directed stimulus, an imem responder and a program-order PC model.
module tb_ysyx_22041211_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        imem_rsp_err_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        fault_o;

    int checks   = 0;
    int failures = 0;

    int          lat;
    int          stall;
    bit          pend;
    int          pend_cnt;
    logic [31:0] pend_addr;

    logic        p_req, p_inst, p_fault;
    logic [31:0] p_addr, p_inst_w, p_pc;
    logic [31:0] mpc;
    bit          stale, ev_redir, ev_acc, ev_cons, held;

    always #5 clk = ~clk;

    ysyx_22041211_ifu dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .imem_rsp_err_i   (imem_rsp_err_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .pc_o             (pc_o),
        .fault_o          (fault_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b11} ^ 32'h0F0F_0000;
        return (a == 32'h8000_0000) ? 32'h0050_0093 : w;
    endfunction

    function automatic bit mem_err(input logic [31:0] a);
        return a == 32'h8000_0008;
    endfunction

    function automatic bit mis(input logic [31:0] a);
`ifdef YSYX_22041211_IFU_ALIGN_CHK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] cap(input logic [31:0] a);
`ifdef YSYX_22041211_IFU_ALIGN_CHK_EN
        return a;
`else
        return {a[31:2], 2'b00};
`endif
    endfunction

    function automatic bit exp_fault(input logic [31:0] a);
        return mem_err(a) || mis(a);
    endfunction

    function automatic logic [31:0] exp_inst(input logic [31:0] a);
        return exp_fault(a) ? NOP : mem_word(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_inst(input string name);
        int n = 0;
        while (!inst_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_inst_seen"}, inst_valid_o, 1);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!imem_req_valid_o && n < 20) begin
            chk({name, "_no_stale_valid"}, inst_valid_o, 0);
            @(negedge clk);
            n++;
        end
        chk({name, "_req_seen"}, imem_req_valid_o, 1);
    endtask

    task automatic consume();
        inst_ready_i = 1'b1;
        @(negedge clk);
        inst_ready_i = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = tgt;
        @(negedge clk);
        redirect_valid_i = 1'b0;
    endtask

    // Instruction memory: one beat per accepted request, after `lat` idle cycles.
    initial begin
        pend = 0; pend_cnt = 0; pend_addr = '0;
        imem_req_ready_i = 1'b1;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        imem_rsp_err_i   = 1'b0;
        forever begin
            @(negedge clk);
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = '0;
            imem_rsp_err_i   = 1'b0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    imem_rsp_valid_i = 1'b1;
                    imem_rsp_data_i  = mem_word(pend_addr);
                    imem_rsp_err_i   = mem_err(pend_addr);
                    pend = 0;
                end else begin
                    pend_cnt--;
                end
            end
            if (stall > 0) begin
                imem_req_ready_i = 1'b0;
                if (imem_req_valid_o) stall--;
            end else begin
                imem_req_ready_i = 1'b1;
            end
            if (imem_req_valid_o && imem_req_ready_i) begin
                pend      = 1;
                pend_cnt  = lat;
                pend_addr = imem_req_addr_o;
            end
        end
    end

    // Every cycle: the delivered instruction stream must follow program order from the model PC.
    initial begin
        stale = 0;
        mpc   = RST_PC;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                chk("cyc_reset_req_valid", imem_req_valid_o, 0);
                chk("cyc_reset_inst_valid", inst_valid_o, 0);
                chk("cyc_reset_addr", imem_req_addr_o, RST_PC);
                mpc   = RST_PC;
                stale = 0;
            end else begin
                ev_redir = redirect_valid_i;
                ev_acc   = p_req && imem_req_ready_i;
                ev_cons  = p_inst && inst_ready_i && !ev_redir;
                if (ev_redir && p_req) stale = 1;
                if (ev_redir) mpc = cap(redirect_pc_i);
                else if (ev_cons) mpc = mpc + 32'd4;
                if (ev_acc) begin
                    if (stale) stale = 0;
                    else chk("cyc_req_addr", p_addr, mpc);
                end
                chk("cyc_single_outstanding", imem_req_valid_o & inst_valid_o, 0);
                if (p_req && !imem_req_ready_i) begin
                    chk("cyc_req_held", imem_req_valid_o, 1);
                    chk("cyc_addr_stable", imem_req_addr_o, p_addr);
                end
                held = p_inst && !ev_cons && !ev_redir;
                if (held) begin
                    chk("cyc_hold_valid", inst_valid_o, 1);
                    chk("cyc_hold_inst", inst_o, p_inst_w);
                    chk("cyc_hold_pc", pc_o, p_pc);
                    chk("cyc_hold_fault", fault_o, p_fault);
                end else if (inst_valid_o) begin
                    chk("cyc_new_pc", pc_o, mpc);
                    chk("cyc_new_inst", inst_o, exp_inst(mpc));
                    chk("cyc_new_fault", fault_o, exp_fault(mpc));
                end
                if (ev_redir && p_inst && !mis(redirect_pc_i))
                    chk("cyc_redirect_drops_word", inst_valid_o, 0);
            end
            p_req    = imem_req_valid_o;
            p_addr   = imem_req_addr_o;
            p_inst   = inst_valid_o;
            p_inst_w = inst_o;
            p_pc     = pc_o;
            p_fault  = fault_o;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = '0; inst_ready_i = 1'b0;
        lat = 0; stall = 0;
        repeat (3) @(negedge clk);
        chk("rst_req_valid", imem_req_valid_o, 0);
        chk("rst_addr", imem_req_addr_o, RST_PC);
        chk("rst_inst_valid", inst_valid_o, 0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_pc", pc_o, RST_PC);
        chk("rst_fault", fault_o, 0);

        // First fetch: request after release, accept, 1-cycle response.
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_req_valid", imem_req_valid_o, 1);
        chk("first_req_addr", imem_req_addr_o, 32'h8000_0000);
        @(negedge clk);
        chk("first_wait_valid", inst_valid_o, 0);
        @(negedge clk);
        chk("first_inst_valid", inst_valid_o, 1);
        chk("first_inst", inst_o, 32'h0050_0093);
        chk("first_pc", pc_o, 32'h8000_0000);
        chk("first_fault", fault_o, 0);
        repeat (5) begin
            @(negedge clk);
            chk("stall_inst_valid", inst_valid_o, 1);
            chk("stall_no_req", imem_req_valid_o, 0);
            chk("stall_inst", inst_o, 32'h0050_0093);
            chk("stall_pc", pc_o, 32'h8000_0000);
        end
        consume();
        chk("next_req_valid", imem_req_valid_o, 1);
        chk("next_req_addr", imem_req_addr_o, 32'h8000_0004);
        wait_inst("second");
        chk("second_inst", inst_o, 32'h8F0F_0007);
        chk("second_pc", pc_o, 32'h8000_0004);
        consume();

        // Access fault at 0x80000008.
        wait_inst("err");
        chk("err_inst", inst_o, NOP);
        chk("err_fault", fault_o, 1);
        chk("err_pc", pc_o, 32'h8000_0008);

        // Redirect while waiting for the response.
        lat = 2;
        consume();
        chk("wait_case_addr", imem_req_addr_o, 32'h8000_000C);
        @(negedge clk);
        chk("wait_case_in_wait", imem_req_valid_o, 0);
        redirect(32'h8000_0100);
        lat = 0;
        wait_req("redir_wait");
        chk("redir_wait_addr", imem_req_addr_o, 32'h8000_0100);
        wait_inst("redir_wait");
        chk("redir_wait_pc", pc_o, 32'h8000_0100);
        chk("redir_wait_inst", inst_o, 32'h8F0F_0103);

        // Redirects while the request is stalled; the newer target wins.
        stall = 3;
        consume();
        chk("req_stall_addr0", imem_req_addr_o, 32'h8000_0104);
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h8000_0300;
        @(negedge clk);
        chk("req_stall_valid1", imem_req_valid_o, 1);
        chk("req_stall_addr1", imem_req_addr_o, 32'h8000_0104);
        redirect_pc_i = 32'h8000_0200;
        @(negedge clk);
        redirect_valid_i = 1'b0;
        chk("req_stall_addr2", imem_req_addr_o, 32'h8000_0104);
        @(negedge clk);
        chk("req_stall_addr3", imem_req_addr_o, 32'h8000_0104);
        @(negedge clk);
        wait_req("kill");
        chk("kill_target_addr", imem_req_addr_o, 32'h8000_0200);
        wait_inst("kill");
        chk("kill_target_pc", pc_o, 32'h8000_0200);
        chk("kill_target_inst", inst_o, 32'h8F0F_0203);

        // Redirect in HOLD together with a consume, then PC wrap.
        redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; inst_ready_i = 1'b1;
        @(negedge clk);
        redirect_valid_i = 1'b0; inst_ready_i = 1'b0;
        chk("hold_redir_drop", inst_valid_o, 0);
        chk("hold_redir_addr", imem_req_addr_o, 32'hFFFF_FFFC);
        wait_inst("top");
        chk("top_pc", pc_o, 32'hFFFF_FFFC);
        consume();
        chk("wrap_req_valid", imem_req_valid_o, 1);
        chk("wrap_addr", imem_req_addr_o, 32'h0000_0000);
        wait_inst("wrap");
        chk("wrap_pc", pc_o, 32'h0000_0000);

        // Misaligned redirect target.
        redirect(32'h8000_0102);
`ifdef YSYX_22041211_IFU_ALIGN_CHK_EN
        chk("mis_valid", inst_valid_o, 1);
        chk("mis_fault", fault_o, 1);
        chk("mis_pc", pc_o, 32'h8000_0102);
        chk("mis_inst", inst_o, NOP);
        chk("mis_no_req", imem_req_valid_o, 0);
        @(negedge clk);
        chk("mis_still_no_req", imem_req_valid_o, 0);
`else
        chk("mis_req_valid", imem_req_valid_o, 1);
        chk("mis_aligned_addr", imem_req_addr_o, 32'h8000_0100);
        wait_inst("mis");
        chk("mis_aligned_pc", pc_o, 32'h8000_0100);
        chk("mis_fault", fault_o, 0);
`endif
        redirect(32'h8000_0200);
        wait_inst("after_mis");
        chk("after_mis_pc", pc_o, 32'h8000_0200);

        // Reset mid-transaction; the late beat lands while the FSM is in IDLE.
        lat = 2;
        consume();
        @(negedge clk);
        chk("pre_reset_wait", imem_req_valid_o, 0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("in_reset_pc", pc_o, RST_PC);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_req_valid", imem_req_valid_o, 1);
        chk("post_reset_addr", imem_req_addr_o, RST_PC);
        chk("post_reset_no_valid", inst_valid_o, 0);
        wait_inst("post_reset");
        lat = 0;
        chk("post_reset_pc", pc_o, RST_PC);
        chk("post_reset_inst", inst_o, 32'h0050_0093);
        consume();
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
